// File: rtl/regfile_dual_write_param.sv
// Dual-write, quad-read register file with same-cycle write bypass, a registered
// same-address write-conflict flag and a per-register busy scoreboard.
module regfile_dual_write_param #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
   parameter bit          ZERO_REG = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              regWrite1,
   input  logic [ADDR_W-1:0] writeReg1,
   input  logic [DATA_W-1:0] writeData1,
   input  logic              regWrite2,
   input  logic [ADDR_W-1:0] writeReg2,
   input  logic [DATA_W-1:0] writeData2,
   input  logic [ADDR_W-1:0] readReg1,
   input  logic [ADDR_W-1:0] readReg2,
   input  logic [ADDR_W-1:0] readReg3,
   input  logic [ADDR_W-1:0] readReg4,
   output logic [DATA_W-1:0] readData1,
   output logic [DATA_W-1:0] readData2,
   output logic [DATA_W-1:0] readData3,
   output logic [DATA_W-1:0] readData4,
   output logic              readBusy1,
   output logic              readBusy2,
   output logic              readBusy3,
   output logic              readBusy4,
   input  logic              setBusy,
   input  logic [ADDR_W-1:0] setReg,
   output logic              wrConflict
);

   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [NUM_REGS-1:0] busy_q, busy_d;
   logic [NUM_REGS-1:0] wr1_dec, wr2_dec, set_dec;
   logic                wr_conflict_q, wr_conflict_d;

   logic [ADDR_W-1:0]   rd_addr [4];
   logic [DATA_W-1:0]   rd_data [4];
   logic [3:0]          rd_busy;

   // One-hot decodes are gated by their enables so X on a disabled port never propagates.
   always_comb begin
      wr1_dec = '0;
      wr2_dec = '0;
      set_dec = '0;
      if (regWrite1) wr1_dec[writeReg1] = 1'b1;
      if (regWrite2) wr2_dec[writeReg2] = 1'b1;
      if (setBusy)   set_dec[setReg]    = 1'b1;
      if (ZERO_REG) begin
         wr1_dec[0] = 1'b0;
         wr2_dec[0] = 1'b0;
         set_dec[0] = 1'b0;
      end
      wr_conflict_d = |(wr1_dec & wr2_dec);
      // A new producer outranks the retiring write on the same register.
      busy_d        = (busy_q & ~(wr1_dec | wr2_dec)) | set_dec;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
         busy_q        <= '0;
         wr_conflict_q <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wr2_dec[i]) begin
               regs_q[i] <= writeData2;
            end else if (wr1_dec[i]) begin
               regs_q[i] <= writeData1;
            end
         end
         busy_q        <= busy_d;
         wr_conflict_q <= wr_conflict_d;
      end
   end

   assign rd_addr[0] = readReg1;
   assign rd_addr[1] = readReg2;
   assign rd_addr[2] = readReg3;
   assign rd_addr[3] = readReg4;

   // Port 2 carries the younger instruction, so its bypass takes priority.
   always_comb begin
      for (int p = 0; p < 4; p++) begin
         rd_busy[p] = busy_q[rd_addr[p]];
         if (regWrite2 && (writeReg2 == rd_addr[p])) begin
            rd_data[p] = writeData2;
         end else if (regWrite1 && (writeReg1 == rd_addr[p])) begin
            rd_data[p] = writeData1;
         end else begin
            rd_data[p] = regs_q[rd_addr[p]];
         end
         if (ZERO_REG && (rd_addr[p] == '0)) begin
            rd_data[p] = '0;
            rd_busy[p] = 1'b0;
         end
      end
   end

   assign readData1  = rd_data[0];
   assign readData2  = rd_data[1];
   assign readData3  = rd_data[2];
   assign readData4  = rd_data[3];
   assign readBusy1  = rd_busy[0];
   assign readBusy2  = rd_busy[1];
   assign readBusy3  = rd_busy[2];
   assign readBusy4  = rd_busy[3];
   assign wrConflict = wr_conflict_q;

endmodule

// File: tb/tb_regfile_dual_write_param.sv
// Drives a 32x32 and an 8x16 instance with shared stimulus; a reference model feeds a
// scoreboard queue, and a vector table adds fixed expectations for the corner cases.
`timescale 1ns/1ps
module tb_regfile_dual_write_param;

   typedef struct {
      logic            rst;
      logic            we1;
      logic [4:0]      wa1;
      logic [31:0]     wd1;
      logic            we2;
      logic [4:0]      wa2;
      logic [31:0]     wd2;
      logic            sb;
      logic [4:0]      sr;
      logic [3:0][4:0] ra;
      logic            chk;
      logic [31:0]     exp_d;
      logic            exp_b;
      logic            exp_c;
   } vec_t;

   typedef struct {
      logic [3:0][31:0] d;
      logic [3:0]       b;
      logic             c;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst;
   logic            we1, we2, sb;
   logic [4:0]      wa1, wa2, sr;
   logic [31:0]     wd1, wd2;
   logic [4:0]      ra [4];

   logic [31:0]     got_d [2][4];
   logic [15:0]     b_rd [4];
   logic            got_b [2][4];
   logic            got_c [2];

   int unsigned     n_cmp = 0;
   int unsigned     n_bad = 0;

   logic [31:0]     m_reg  [2][32];
   logic [31:0]     m_busy [2];
   logic            m_conf [2];
   logic [4:0]      am [2];
   logic [31:0]     dm [2];
   exp_t            sb_q [$];
   vec_t            tbl [14];

   regfile_dual_write_param u_dut_a (
      .clk(clk), .reset(rst),
      .regWrite1(we1), .writeReg1(wa1), .writeData1(wd1),
      .regWrite2(we2), .writeReg2(wa2), .writeData2(wd2),
      .readReg1(ra[0]), .readReg2(ra[1]), .readReg3(ra[2]), .readReg4(ra[3]),
      .readData1(got_d[0][0]), .readData2(got_d[0][1]),
      .readData3(got_d[0][2]), .readData4(got_d[0][3]),
      .readBusy1(got_b[0][0]), .readBusy2(got_b[0][1]),
      .readBusy3(got_b[0][2]), .readBusy4(got_b[0][3]),
      .setBusy(sb), .setReg(sr), .wrConflict(got_c[0])
   );

   regfile_dual_write_param #(.DATA_W(16), .NUM_REGS(8), .ADDR_W(3), .ZERO_REG(1'b1)) u_dut_b (
      .clk(clk), .reset(rst),
      .regWrite1(we1), .writeReg1(wa1[2:0]), .writeData1(wd1[15:0]),
      .regWrite2(we2), .writeReg2(wa2[2:0]), .writeData2(wd2[15:0]),
      .readReg1(ra[0][2:0]), .readReg2(ra[1][2:0]), .readReg3(ra[2][2:0]),
      .readReg4(ra[3][2:0]),
      .readData1(b_rd[0]), .readData2(b_rd[1]), .readData3(b_rd[2]), .readData4(b_rd[3]),
      .readBusy1(got_b[1][0]), .readBusy2(got_b[1][1]),
      .readBusy3(got_b[1][2]), .readBusy4(got_b[1][3]),
      .setBusy(sb), .setReg(sr[2:0]), .wrConflict(got_c[1])
   );

   always_comb begin
      for (int p = 0; p < 4; p++) got_d[1][p] = {16'h0, b_rd[p]};
   end

   function automatic logic [31:0] m_rd(input int c, input logic [4:0] addr);
      logic [4:0] a;
      a = addr & am[c];
      if (a == 5'd0) return 32'h0;
      if (we2 && ((wa2 & am[c]) == a)) return wd2 & dm[c];
      if (we1 && ((wa1 & am[c]) == a)) return wd1 & dm[c];
      return m_reg[c][a];
   endfunction

   function automatic logic m_bz(input int c, input logic [4:0] addr);
      logic [4:0] a;
      a = addr & am[c];
      return (a == 5'd0) ? 1'b0 : m_busy[c][a];
   endfunction

   task automatic model_edge();
      logic [4:0] a1, a2, s;
      for (int c = 0; c < 2; c++) begin
         if (rst) begin
            for (int i = 0; i < 32; i++) m_reg[c][i] = 32'h0;
            m_busy[c] = 32'h0;
            m_conf[c] = 1'b0;
         end else begin
            a1 = wa1 & am[c];
            a2 = wa2 & am[c];
            s  = sr & am[c];
            if (we1 && a1 != 0) m_reg[c][a1] = wd1 & dm[c];
            if (we2 && a2 != 0) m_reg[c][a2] = wd2 & dm[c];
            m_conf[c] = we1 && we2 && (a1 == a2) && (a1 != 0);
            if (we1) m_busy[c][a1] = 1'b0;
            if (we2) m_busy[c][a2] = 1'b0;
            if (sb && s != 0) m_busy[c][s] = 1'b1;
            m_busy[c][0] = 1'b0;
         end
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Drive one cycle, queue the model's view, compare at the falling edge, then commit.
   task automatic run_cycle(input vec_t v);
      exp_t e;
      rst = v.rst;
      we1 = v.we1; wa1 = v.we1 ? v.wa1 : 'x; wd1 = v.we1 ? v.wd1 : 'x;
      we2 = v.we2; wa2 = v.we2 ? v.wa2 : 'x; wd2 = v.we2 ? v.wd2 : 'x;
      sb  = v.sb;  sr  = v.sb ? v.sr : 'x;
      for (int p = 0; p < 4; p++) ra[p] = v.ra[p];
      for (int c = 0; c < 2; c++) begin
         for (int p = 0; p < 4; p++) begin
            e.d[p] = m_rd(c, v.ra[p]);
            e.b[p] = m_bz(c, v.ra[p]);
         end
         e.c = m_conf[c];
         sb_q.push_back(e);
      end
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
         e = sb_q.pop_front();
         for (int p = 0; p < 4; p++) begin
            check($sformatf("cfg%0d data%0d", c, p + 1), got_d[c][p], e.d[p]);
            check($sformatf("cfg%0d busy%0d", c, p + 1), {31'h0, got_b[c][p]}, {31'h0, e.b[p]});
         end
         check($sformatf("cfg%0d wrConflict", c), {31'h0, got_c[c]}, {31'h0, e.c});
         if (v.chk) begin
            for (int p = 0; p < 4; p++) begin
               check($sformatf("vec cfg%0d data%0d", c, p + 1), got_d[c][p], v.exp_d & dm[c]);
               check($sformatf("vec cfg%0d busy%0d", c, p + 1), {31'h0, got_b[c][p]},
                     {31'h0, v.exp_b});
            end
            check($sformatf("vec cfg%0d wrConflict", c), {31'h0, got_c[c]}, {31'h0, v.exp_c});
         end
      end
      @(posedge clk);
      model_edge();
      #1;
   endtask

   function automatic vec_t mk(input logic r, input logic w1, input logic [4:0] a1,
                               input logic [31:0] d1, input logic w2, input logic [4:0] a2,
                               input logic [31:0] d2, input logic s, input logic [4:0] sa,
                               input logic [4:0] rd, input logic k, input logic [31:0] ed,
                               input logic eb, input logic ec);
      vec_t v;
      v.rst = r; v.we1 = w1; v.wa1 = a1; v.wd1 = d1; v.we2 = w2; v.wa2 = a2; v.wd2 = d2;
      v.sb = s; v.sr = sa;
      for (int p = 0; p < 4; p++) v.ra[p] = rd;
      v.chk = k; v.exp_d = ed; v.exp_b = eb; v.exp_c = ec;
      return v;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected end by 2000000 ns");
      $fatal(1);
   end

   initial begin
      vec_t v;
      am[0] = 5'd31; am[1] = 5'd7;
      dm[0] = 32'hFFFF_FFFF; dm[1] = 32'h0000_FFFF;

      //           rst we1 wa1 wd1           we2 wa2 wd2           sb sr  rd  chk exp_d    b  c
      tbl[0]  = mk(1, 0, 0, 0,            0, 0, 0,            0, 0, 5, 0, 0,            0, 0);
      tbl[1]  = mk(1, 1, 3, 32'hA5A5_0001, 0, 0, 0,           0, 0, 3, 1, 32'hA5A5_0001, 0, 0);
      tbl[2]  = mk(0, 0, 0, 0,            0, 0, 0,            0, 0, 3, 1, 32'h0,         0, 0);
      tbl[3]  = mk(0, 1, 5, 32'h1111_1111, 1, 5, 32'h2222_2222, 0, 0, 5, 1, 32'h2222_2222, 0, 0);
      tbl[4]  = mk(0, 0, 0, 0,            0, 0, 0,            0, 0, 5, 1, 32'h2222_2222, 0, 1);
      tbl[5]  = mk(0, 0, 0, 0,            0, 0, 0,            0, 0, 5, 1, 32'h2222_2222, 0, 0);
      tbl[6]  = mk(0, 1, 0, 32'hDEAD_BEEF, 1, 0, 32'hDEAD_BEEF, 1, 0, 0, 1, 32'h0,       0, 0);
      tbl[7]  = mk(0, 0, 0, 0,            0, 0, 0,            0, 0, 0, 1, 32'h0,         0, 0);
      tbl[8]  = mk(0, 0, 0, 0,            0, 0, 0,            1, 7, 7, 1, 32'h0,         0, 0);
      tbl[9]  = mk(0, 1, 7, 32'h77,       0, 0, 0,            1, 7, 7, 1, 32'h77,        1, 0);
      tbl[10] = mk(0, 0, 0, 0,            1, 7, 32'h88,       0, 0, 7, 1, 32'h88,        1, 0);
      tbl[11] = mk(0, 0, 0, 0,            0, 0, 0,            0, 0, 7, 1, 32'h88,        0, 0);
      tbl[12] = mk(0, 1, 9, 32'hFF,       0, 0, 0,            0, 0, 9, 1, 32'hFF,        0, 0);
      tbl[13] = mk(0, 0, 0, 0,            0, 0, 0,            0, 0, 9, 1, 32'hFF,        0, 0);

      rst = 1'b1; we1 = 1'b0; we2 = 1'b0; sb = 1'b0;
      wa1 = '0; wa2 = '0; wd1 = '0; wd2 = '0; sr = '0;
      for (int p = 0; p < 4; p++) ra[p] = '0;
      repeat (2) @(posedge clk);
      model_edge();
      #1;

      // Random traffic, including collisions, reg 0 and X on disabled ports.
      for (int n = 0; n < 80; n++) begin
         v = mk(0, $urandom_range(0, 1) == 1, 5'($urandom), $urandom,
                $urandom_range(0, 1) == 1, 5'($urandom), $urandom,
                $urandom_range(0, 2) != 0, 5'($urandom), 0, 0, 0, 0, 0);
         if ($urandom_range(0, 3) == 0) v.wa2 = v.wa1;
         for (int p = 0; p < 4; p++) v.ra[p] = 5'($urandom);
         if ($urandom_range(0, 3) == 0) v.ra[0] = v.wa1;
         if ($urandom_range(0, 3) == 0) v.ra[1] = v.wa2;
         run_cycle(v);
      end

      for (int i = 0; i < 14; i++) run_cycle(tbl[i]);

      if (sb_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard drain: got %0d left expected 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
